// File: rtl/ctrl_seq.sv
// ctrl_seq: instruction sequencer for the accumulator datapath.
// It fetches an instruction through a req/ack memory handshake, decodes the
// 4-bit opcode and issues one-cycle control strobes to the datapath registers.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            level; leaves IDLE, and must fall to leave HALT
//   opcode           IR[15:12]; used in DECODE/EXA/EXB only
//   z_flag           ALU zero flag, sampled in DECODE (JMPZ)
//   mem_ack          memory completes the pending read/write this cycle
//   mem_read/write   memory request, held until mem_ack
//   bus_sel          bus source: 0 MEM, 1 PC, 2 IR, 3 AC, 4 R
//   pc_*, ar_write, ir_write      register strobes
//   ac_*, alu_to_ac, alu_op       accumulator / ALU strobes
//   done, err        halted normally / halted on an illegal opcode
//
// Outputs are decoded from the state register (and mem_ack in the wait
// states) rather than registered. That lets the ack-cycle strobes line up with
// the memory, and it lets reset clear every output in the same cycle.
module ctrl_seq #(
  parameter int unsigned N = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       z_flag,
  input  logic       mem_ack,
  output logic       mem_read,
  output logic       mem_write,
  output logic [2:0] bus_sel,
  output logic       pc_inc,
  output logic       pc_write,
  output logic       ar_write,
  output logic       ir_write,
  output logic       ac_write,
  output logic       ac_inc,
  output logic       ac_clr,
  output logic       ac_to_r,
  output logic       alu_to_ac,
  output logic [1:0] alu_op,
  output logic       done,
  output logic       err
);

  // Bus width only matters to the datapath; reject nonsensical instances.
  if (N < 4) begin : g_bus_too_narrow
    $error("ctrl_seq: N must be at least 4");
  end

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LDAC  = 4'd1;
  localparam logic [3:0] OP_STAC  = 4'd2;
  localparam logic [3:0] OP_MVACR = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_MUL   = 4'd6;
  localparam logic [3:0] OP_INCAC = 4'd7;
  localparam logic [3:0] OP_CLAC  = 4'd8;
  localparam logic [3:0] OP_JMPZ  = 4'd9;
  localparam logic [3:0] OP_END   = 4'd15;

  localparam logic [2:0] BUS_MEM = 3'd0;
  localparam logic [2:0] BUS_PC  = 3'd1;
  localparam logic [2:0] BUS_IR  = 3'd2;
  localparam logic [2:0] BUS_AC  = 3'd3;

  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_SUB = 2'd2;
  localparam logic [1:0] ALU_MUL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH1 = 3'd1,
    S_FETCH2 = 3'd2,
    S_DECODE = 3'd3,
    S_EXA    = 3'd4,
    S_EXB    = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t state, state_nxt;
  logic   err_q, err_nxt;

  // State and halt-cause registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
    end
  end

  // Next-state logic; err_q is only written on the way into or out of HALT.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH1;
      S_FETCH1: state_nxt = S_FETCH2;
      S_FETCH2: if (mem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOP: state_nxt = S_FETCH1;
          OP_LDAC, OP_STAC, OP_MVACR, OP_ADD, OP_SUB, OP_MUL,
          OP_INCAC, OP_CLAC: state_nxt = S_EXA;
          OP_JMPZ: state_nxt = z_flag ? S_EXA : S_FETCH1;
          OP_END: begin
            state_nxt = S_HALT;
            err_nxt   = 1'b0;
          end
          default: begin
            state_nxt = S_HALT;
            err_nxt   = 1'b1;
          end
        endcase
      end
      S_EXA: state_nxt = (opcode == OP_LDAC || opcode == OP_STAC) ? S_EXB : S_FETCH1;
      S_EXB: if (mem_ack) state_nxt = S_FETCH1;
      S_HALT: begin
        if (!start) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: every strobe defaults low and is raised only where used.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    bus_sel   = BUS_MEM;
    pc_inc    = 1'b0;
    pc_write  = 1'b0;
    ar_write  = 1'b0;
    ir_write  = 1'b0;
    ac_write  = 1'b0;
    ac_inc    = 1'b0;
    ac_clr    = 1'b0;
    ac_to_r   = 1'b0;
    alu_to_ac = 1'b0;
    alu_op    = 2'd0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_FETCH1: begin
        bus_sel  = BUS_PC;
        ar_write = 1'b1;
      end
      S_FETCH2: begin
        mem_read = 1'b1;
        ir_write = mem_ack;
        pc_inc   = mem_ack;
      end
      S_EXA: begin
        case (opcode)
          OP_LDAC, OP_STAC: begin
            bus_sel  = BUS_IR;
            ar_write = 1'b1;
          end
          OP_MVACR: begin
            bus_sel = BUS_AC;
            ac_to_r = 1'b1;
          end
          OP_ADD: begin
            alu_op    = ALU_ADD;
            alu_to_ac = 1'b1;
          end
          OP_SUB: begin
            alu_op    = ALU_SUB;
            alu_to_ac = 1'b1;
          end
          OP_MUL: begin
            alu_op    = ALU_MUL;
            alu_to_ac = 1'b1;
          end
          OP_INCAC: ac_inc = 1'b1;
          OP_CLAC:  ac_clr = 1'b1;
          OP_JMPZ: begin
            bus_sel  = BUS_IR;
            pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXB: begin
        if (opcode == OP_LDAC) begin
          mem_read = 1'b1;
          ac_write = mem_ack;
        end else if (opcode == OP_STAC) begin
          mem_write = 1'b1;
          bus_sel   = BUS_AC;
        end
      end
      S_HALT: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed testbench for ctrl_seq. All outputs are packed into one vector and
// compared against hand-built expected vectors every cycle.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] opcode;
  logic       z_flag;
  logic       mem_ack;
  logic       mem_read, mem_write;
  logic [2:0] bus_sel;
  logic       pc_inc, pc_write, ar_write, ir_write;
  logic       ac_write, ac_inc, ac_clr, ac_to_r, alu_to_ac;
  logic [1:0] alu_op;
  logic       done, err;

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_seq #(.N(16)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .z_flag(z_flag),
    .mem_ack(mem_ack), .mem_read(mem_read), .mem_write(mem_write),
    .bus_sel(bus_sel), .pc_inc(pc_inc), .pc_write(pc_write),
    .ar_write(ar_write), .ir_write(ir_write), .ac_write(ac_write),
    .ac_inc(ac_inc), .ac_clr(ac_clr), .ac_to_r(ac_to_r),
    .alu_to_ac(alu_to_ac), .alu_op(alu_op), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [17:0] outs;
  assign outs = {mem_read, mem_write, bus_sel, pc_inc, pc_write, ar_write,
                 ir_write, ac_write, ac_inc, ac_clr, ac_to_r, alu_to_ac,
                 alu_op, done, err};

  localparam logic [17:0] NONE  = 18'd0;
  localparam logic [17:0] O_RD  = 18'(1) << 17;
  localparam logic [17:0] O_WR  = 18'(1) << 16;
  localparam logic [17:0] O_PCI = 18'(1) << 12;
  localparam logic [17:0] O_PCW = 18'(1) << 11;
  localparam logic [17:0] O_ARW = 18'(1) << 10;
  localparam logic [17:0] O_IRW = 18'(1) << 9;
  localparam logic [17:0] O_ACW = 18'(1) << 8;
  localparam logic [17:0] O_ACI = 18'(1) << 7;
  localparam logic [17:0] O_ACC = 18'(1) << 6;
  localparam logic [17:0] O_ACR = 18'(1) << 5;
  localparam logic [17:0] O_ALU = 18'(1) << 4;
  localparam logic [17:0] O_DON = 18'(1) << 1;
  localparam logic [17:0] O_ERR = 18'(1) << 0;

  function automatic logic [17:0] bs(input logic [2:0] s);
    return 18'(s) << 13;
  endfunction

  function automatic logic [17:0] aop(input logic [1:0] op);
    return 18'(op) << 2;
  endfunction

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply mem_ack, check this cycle's outputs, then advance one clock.
  task automatic cyc(input string tag, input logic ack, input logic [17:0] exp);
    mem_ack = ack;
    #1;
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  // FETCH1 + FETCH2 with the given number of wait cycles before ack.
  task automatic fetch(input logic [3:0] op, input int waits);
    opcode = op;
    cyc("fetch1", 1'b1, O_ARW | bs(3'd1));
    for (int i = 0; i < waits; i++) cyc("fetch2_wait", 1'b0, O_RD);
    cyc("fetch2_ack", 1'b1, O_RD | O_IRW | O_PCI);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 4'd0; z_flag = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs, NONE);
    rst = 1'b0;
    cyc("idle_hold", 1'b0, NONE);
    start = 1'b1;
    cyc("idle_start", 1'b0, NONE);

    // Reset while FETCH2 waits for ack.
    opcode = 4'd4;
    cyc("fetch1", 1'b0, O_ARW | bs(3'd1));
    cyc("fetch2_wait", 1'b0, O_RD);
    mem_ack = 1'b0;
    #1;
    check("fetch2_wait2", outs, O_RD);
    rst = 1'b1;
    #1;
    check("rst_mid_fetch", outs, NONE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("rst_release_idle", 1'b0, NONE);

    // ADD: ack in DECODE/EXA must be ignored.
    fetch(4'd4, 0);
    cyc("add_decode", 1'b1, NONE);
    cyc("add_exa", 1'b1, O_ALU | aop(2'd1));
    // SUB, MUL
    fetch(4'd5, 0);
    cyc("sub_decode", 1'b0, NONE);
    cyc("sub_exa", 1'b0, O_ALU | aop(2'd2));
    fetch(4'd6, 0);
    cyc("mul_decode", 1'b0, NONE);
    cyc("mul_exa", 1'b0, O_ALU | aop(2'd3));
    // LDAC with two EXB wait cycles.
    fetch(4'd1, 0);
    cyc("ldac_decode", 1'b0, NONE);
    cyc("ldac_exa", 1'b0, O_ARW | bs(3'd2));
    cyc("ldac_exb_wait", 1'b0, O_RD);
    cyc("ldac_exb_wait", 1'b0, O_RD);
    cyc("ldac_exb_ack", 1'b1, O_RD | O_ACW);
    // MVACR then STAC with one wait cycle.
    fetch(4'd3, 0);
    cyc("mvacr_decode", 1'b0, NONE);
    cyc("mvacr_exa", 1'b0, O_ACR | bs(3'd3));
    fetch(4'd2, 0);
    cyc("stac_decode", 1'b0, NONE);
    cyc("stac_exa", 1'b0, O_ARW | bs(3'd2));
    cyc("stac_exb_wait", 1'b0, O_WR | bs(3'd3));
    cyc("stac_exb_ack", 1'b1, O_WR | bs(3'd3));
    // INCAC, CLAC
    fetch(4'd7, 0);
    cyc("incac_decode", 1'b0, NONE);
    cyc("incac_exa", 1'b0, O_ACI);
    fetch(4'd8, 0);
    cyc("clac_decode", 1'b0, NONE);
    cyc("clac_exa", 1'b0, O_ACC);
    // NOP with one fetch wait cycle.
    fetch(4'd0, 1);
    cyc("nop_decode", 1'b0, NONE);
    // JMPZ not taken, then taken.
    z_flag = 1'b0;
    fetch(4'd9, 0);
    cyc("jmpz0_decode", 1'b0, NONE);
    z_flag = 1'b1;
    fetch(4'd9, 0);
    cyc("jmpz1_decode", 1'b0, NONE);
    z_flag = 1'b0;
    cyc("jmpz1_exa", 1'b0, O_PCW | bs(3'd2));

    // Illegal opcode halts with err; start held keeps HALT.
    fetch(4'd12, 0);
    cyc("ill_decode", 1'b0, NONE);
    cyc("halt_err", 1'b1, O_DON | O_ERR);
    cyc("halt_err_hold", 1'b0, O_DON | O_ERR);
    start = 1'b0;
    cyc("halt_err_drop", 1'b0, O_DON | O_ERR);
    cyc("idle_after_err", 1'b0, NONE);
    start = 1'b1;
    cyc("idle_restart", 1'b0, NONE);

    // END halts without err.
    fetch(4'd15, 0);
    cyc("end_decode", 1'b0, NONE);
    cyc("halt_done", 1'b0, O_DON);
    start = 1'b0;
    cyc("halt_done_drop", 1'b0, O_DON);
    cyc("idle_final", 1'b0, NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
